// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction, data and RAM bus signals of the memory arbiter
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single RAM port to instruction or data requester, alternating under contention
module mem_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input logic CLK,
   input logic RST,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DATA, INSTR, FAULT} state_t;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR = 2'd3;
   state_t state;
   logic last;
   logic [7:0] cnt;
   logic dreq, access, granted;
   logic [7:0] cnt_inc;
   assign dreq = bus.dREN | bus.dWEN;
   assign access = bus.ramstate == ACCESS;
   assign granted = (state == DATA) ? dreq : bus.iREN;
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   // Grant decision, completion, withdrawal and timeout/error handling; last=1 means instruction was granted last
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         last <= 1'b1;
         cnt <= 8'd0;
         bus.err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dreq && (!bus.iREN || last)) begin
                  state <= DATA;
                  last <= 1'b0;
                  cnt <= 8'd0;
               end else if (bus.iREN) begin
                  state <= INSTR;
                  last <= 1'b1;
                  cnt <= 8'd0;
               end
            end
            DATA, INSTR: begin
               if (access || !granted) state <= IDLE;
               else if (bus.ramstate == ERROR || cnt_inc >= TIMEOUT) begin
                  state <= FAULT;
                  bus.err <= 1'b1;
               end
               if (!access) cnt <= cnt_inc;
            end
            default: bus.err <= 1'b1;
         endcase
      end
   end
   assign bus.ramREN = (state == INSTR) | ((state == DATA) & bus.dREN & ~bus.dWEN);
   assign bus.ramWEN = (state == DATA) & bus.dWEN;
   assign bus.ramaddr = (state == DATA) ? bus.daddr : (state == INSTR) ? bus.iaddr : 32'd0;
   assign bus.ramstore = (state == DATA) ? bus.dstore : 32'd0;
   assign bus.iwait = !((state == INSTR) && access);
   assign bus.dwait = !((state == DATA) && access);
   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for the memory arbiter
module tb_mem_arbiter;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
   typedef struct {
      logic        kind;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int passed = 0;
   int total = 0;
   int grants;
   exp_t exp_q[$];
   exp_t it;
   mem_arbiter_if b();
   mem_arbiter_if b2();
   mem_arbiter u_dut (.CLK(CLK), .RST(RST), .bus(b));
   mem_arbiter #(.TIMEOUT(8'd4)) u_dut2 (.CLK(CLK), .RST(RST), .bus(b2));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic idle_inputs();
      b.iREN = 0; b.iaddr = 0; b.dREN = 0; b.dWEN = 0; b.daddr = 0; b.dstore = 0;
      b.ramload = 0; b.ramstate = FREE;
      b2.iREN = 0; b2.iaddr = 0; b2.dREN = 0; b2.dWEN = 0; b2.daddr = 0; b2.dstore = 0;
      b2.ramload = 0; b2.ramstate = FREE;
   endtask
   task automatic pulse_rst();
      step();
      RST = 1;
      #2;
      RST = 0;
   endtask
   initial begin
      idle_inputs();
      #2;
      chk("rst_ren", b.ramREN, 0);
      chk("rst_waits", {b.iwait, b.dwait}, 2'b11);
      chk("rst_err", b.err, 0);
      chk("rst_addr", b.ramaddr, 0);
      step();
      RST = 0;
      // single fetch
      b.iREN = 1; b.iaddr = 32'h40; b.ramstate = BUSY;
      #1;
      chk("fetch_latency", b.ramREN, 0);
      step();
      chk("fetch_ren", b.ramREN, 1);
      chk("fetch_addr", b.ramaddr, 32'h40);
      chk("fetch_busy_iwait", b.iwait, 1);
      step();
      b.ramstate = ACCESS; b.ramload = 32'hDEADBEEF;
      #1;
      chk("fetch_iwait", b.iwait, 0);
      chk("fetch_iload", b.iload, 32'hDEADBEEF);
      chk("fetch_dwait", b.dwait, 1);
      step();
      b.iREN = 0; b.ramstate = FREE;
      #1;
      chk("fetch_idle_ren", b.ramREN, 0);
      chk("fetch_idle_iwait", b.iwait, 1);
      // contention from reset: data first, then instruction
      pulse_rst();
      b.iREN = 1; b.iaddr = 32'h40; b.dWEN = 1; b.daddr = 32'h80; b.dstore = 32'h5; b.ramstate = BUSY;
      #1;
      chk("cont_idle_wen", b.ramWEN, 0);
      step();
      chk("cont_wen", b.ramWEN, 1);
      chk("cont_ren", b.ramREN, 0);
      chk("cont_store", b.ramstore, 32'h5);
      chk("cont_daddr", b.ramaddr, 32'h80);
      step();
      b.ramstate = ACCESS;
      #1;
      chk("cont_dwaits", {b.iwait, b.dwait}, 2'b10);
      step();
      b.dWEN = 0; b.ramstate = FREE;
      #1;
      chk("cont_gap", {b.ramREN, b.ramWEN}, 2'b00);
      step();
      b.ramstate = BUSY;
      #1;
      chk("cont_iren", b.ramREN, 1);
      chk("cont_iaddr", b.ramaddr, 32'h40);
      chk("cont_istore", b.ramstore, 0);
      step();
      b.ramstate = ACCESS;
      #1;
      chk("cont_iwaits", {b.iwait, b.dwait}, 2'b01);
      step();
      b.iREN = 0; b.ramstate = FREE;
      // fairness: continuous contention alternates D,I,D,I,D,I
      pulse_rst();
      b.iREN = 1; b.iaddr = 32'h40; b.dREN = 1; b.daddr = 32'h80;
      for (int n = 0; n < 6; n++) exp_q.push_back('{kind: n[0], addr: n[0] ? 32'h40 : 32'h80, data: 32'h1000 + n});
      grants = 0;
      for (int c = 0; c < 80 && grants < 6; c++) begin
         step();
         b.ramstate = BUSY;
         #1;
         if (b.ramREN | b.ramWEN) begin
            it = exp_q.pop_front();
            b.ramstate = ACCESS; b.ramload = it.data;
            #1;
            chk("fair_addr", b.ramaddr, it.addr);
            chk("fair_load", it.kind ? b.iload : b.dload, it.data);
            chk("fair_waits", {b.iwait, b.dwait}, it.kind ? 2'b01 : 2'b10);
            grants++;
            step();
            b.ramstate = FREE;
            #1;
            chk("fair_gap", {b.ramREN, b.ramWEN}, 2'b00);
         end
      end
      chk("fair_count", grants, 6);
      b.iREN = 0; b.dREN = 0;
      // withdrawal during instruction grant
      pulse_rst();
      b.iREN = 1; b.iaddr = 32'h44; b.ramstate = BUSY;
      step();
      chk("wd_ren", b.ramREN, 1);
      b.iREN = 0;
      #1;
      chk("wd_iwait", b.iwait, 1);
      step();
      chk("wd_ren_off", b.ramREN, 0);
      chk("wd_iwait_idle", b.iwait, 1);
      // ERROR ignored while idle
      b.ramstate = ERROR;
      step();
      step();
      chk("idle_error_err", b.err, 0);
      // mid-grant asynchronous reset
      b.ramstate = BUSY; b.dWEN = 1; b.daddr = 32'h88; b.dstore = 32'h9;
      step();
      chk("mid_wen", b.ramWEN, 1);
      RST = 1;
      #1;
      chk("mid_rst_wen", b.ramWEN, 0);
      chk("mid_rst_dwait", b.dwait, 1);
      chk("mid_rst_addr", b.ramaddr, 0);
      RST = 0;
      // ERROR during grant faults the arbiter
      step();
      chk("err_grant", b.ramWEN, 1);
      b.ramstate = ERROR;
      step();
      chk("err_flag", b.err, 1);
      chk("err_wen", b.ramWEN, 0);
      chk("err_dwait", b.dwait, 1);
      b.dWEN = 0;
      pulse_rst();
      #1;
      chk("err_cleared", b.err, 0);
      b.ramstate = FREE;
      // timeout on the TIMEOUT=4 instance
      b2.dREN = 1; b2.daddr = 32'hC0; b2.ramstate = BUSY;
      step();
      chk("to_grant", b2.ramREN, 1);
      step();
      step();
      step();
      chk("to_before", b2.err, 0);
      chk("to_before_ren", b2.ramREN, 1);
      step();
      chk("to_err", b2.err, 1);
      chk("to_ren", b2.ramREN, 0);
      b2.iREN = 1; b2.ramstate = ACCESS;
      step();
      step();
      chk("to_absorb_err", b2.err, 1);
      chk("to_absorb_waits", {b2.iwait, b2.dwait}, 2'b11);
      pulse_rst();
      #1;
      chk("to_rst_err", b2.err, 0);
      chk("to_rst_ren", b2.ramREN, 0);
      idle_inputs();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
